// File: rtl/pe_pkg.sv
// Shared PE definitions: datapath widths, register-file geometry and the
// config-word fields that steer the register-file ports.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 32;
    localparam int RF_DEPTH      = 8;
    localparam int RF_ADDR_WIDTH = $clog2(RF_DEPTH);

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

    // Bit positions of the register-file controls inside the PE config word
    localparam int CFG_RF_WR_EN_BIT   = 0;
    localparam int CFG_RF_WR_ADDR_LSB = 1;
    localparam int CFG_RF_RD_EN_BIT   = CFG_RF_WR_ADDR_LSB + RF_ADDR_WIDTH;
    localparam int CFG_RF_RD_ADDR_LSB = CFG_RF_RD_EN_BIT + 1;
    localparam int CFG_RF_FIELD_W     = CFG_RF_RD_ADDR_LSB + RF_ADDR_WIDTH;

endpackage

// File: rtl/pe_rf_valid_tracker.sv
// Per-entry valid bits of the PE register file; a write in the same cycle
// as a clear leaves its own entry valid.
module pe_rf_valid_tracker
    import pe_pkg::*;
#(
    parameter int DEPTH      = RF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DEPTH-1:0]      entry_valid
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_valid_next;

    always_comb begin
        w_valid_next = clear ? '0 : r_valid;
        if (wr_en) begin
            w_valid_next[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    assign entry_valid = r_valid;

endmodule

// File: rtl/pe_register_file.sv
// Local register file of one SC-CGRA PE: one write port fed by the input
// crossbar, one registered read port (with write bypass) feeding it back.
module pe_register_file
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int DEPTH      = RF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [DEPTH-1:0]      entry_valid
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic [DEPTH-1:0]      w_entry_valid;
    logic                  w_bypass;

    pe_rf_valid_tracker #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_valid_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .entry_valid (w_entry_valid)
    );

    assign w_bypass = wr_en && (wr_addr == rd_addr);

    // Reads sample the pre-edge state, so a concurrent clear never hides the old valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                if (w_bypass) begin
                    r_rd_data  <= wr_data;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_data  <= r_mem[rd_addr];
                    r_rd_valid <= w_entry_valid[rd_addr];
                end
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign entry_valid = w_entry_valid;

endmodule

// File: tb/tb_pe_register_file.sv
// Randomized and directed bench for pe_register_file against an array-based
// model of the register-file rules.
module tb_pe_register_file;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clear;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [DEPTH-1:0] entry_valid;

    pe_register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .clear       (clear),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .entry_valid (entry_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] model_valid_vec();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_val[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_val[i] = 1'b0;
        end
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
    endtask

    task automatic model_edge(input bit we, input int wa, input logic [DW-1:0] wd,
                              input bit re, input int ra, input bit cl);
        if (re) begin
            if (we && wa == ra) begin
                m_rd_data  = wd;
                m_rd_valid = 1'b1;
            end else begin
                m_rd_data  = m_mem[ra];
                m_rd_valid = m_val[ra];
            end
        end
        if (cl) begin
            for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
        end
        if (we) begin
            m_mem[wa] = wd;
            m_val[wa] = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rd_data"}, rd_data, m_rd_data);
        check({tag, ".rd_valid"}, {31'b0, rd_valid}, {31'b0, m_rd_valid});
        check({tag, ".entry_valid"}, {24'b0, entry_valid}, {24'b0, model_valid_vec()});
    endtask

    // Called just after a falling edge: drive, take one rising edge, check at the next falling edge
    task automatic step(input string tag, input bit we, input int wa, input logic [DW-1:0] wd,
                        input bit re, input int ra, input bit cl);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_en   = re;
        rd_addr = AW'(ra);
        clear   = cl;
        @(posedge clk);
        model_edge(we, wa, wd, re, ra, cl);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; clear = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs("reset");

        step("rd_unwritten", 0, 0, '0, 1, 5, 0);
        check("rd_unwritten.data_k", rd_data, 32'h0);

        step("wr3", 1, 3, 32'hDEADBEEF, 0, 0, 0);
        step("rd3", 0, 0, '0, 1, 3, 0);
        check("rd3.data_k", rd_data, 32'hDEADBEEF);
        check("rd3.valid_k", {31'b0, rd_valid}, 32'h1);
        check("rd3.ev_k", {24'b0, entry_valid}, 32'h08);

        step("bypass6", 1, 6, 32'h12345678, 1, 6, 0);
        check("bypass6.data_k", rd_data, 32'h12345678);
        check("bypass6.valid_k", {31'b0, rd_valid}, 32'h1);

        step("reread3", 0, 0, '0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1, 3, 32'h0, 0, 0, 0);
            check("hold.data_k", rd_data, 32'hDEADBEEF);
        end

        for (int i = 0; i < DEPTH; i++) step("fill", 1, i, 32'h100 + i, 0, 0, 0);
        step("clr_wr2", 1, 2, 32'hAA, 0, 0, 1);
        check("clr_wr2.ev_k", {24'b0, entry_valid}, 32'h04);
        step("rd1_after_clr", 0, 0, '0, 1, 1, 0);
        check("rd1_after_clr.data_k", rd_data, 32'h101);
        check("rd1_after_clr.valid_k", {31'b0, rd_valid}, 32'h0);

        // Fill again, then clear while reading: the read must see pre-clear state
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, i, 32'h200 + i, 0, 0, 0);
        step("clr_rd4", 0, 0, '0, 1, 4, 1);
        check("clr_rd4.valid_k", {31'b0, rd_valid}, 32'h1);
        check("clr_rd4.data_k", rd_data, 32'h204);

        for (int n = 0; n < 600; n++) begin
            bit we, re, cl;
            int wa, ra;
            logic [DW-1:0] wd;
            we = bit'($urandom_range(0, 1));
            re = bit'($urandom_range(0, 1));
            cl = ($urandom_range(0, 15) == 0);
            wa = int'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1));
            wd = $urandom;
            step("rand", we, wa, wd, re, ra, cl);
        end

        // Reset dropped between edges during back-to-back writes
        for (int i = 0; i < 3; i++) step("b2b", 1, i, 32'hC0DE0000 + i, 1, i, 0);
        wr_en = 1; wr_addr = 3'd5; wr_data = 32'hFACEFACE; rd_en = 1; rd_addr = 3'd5;
        @(posedge clk);
        model_edge(1, 5, 32'hFACEFACE, 1, 5, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async.rd_data", rd_data, 32'h0);
        check("async.rd_valid", {31'b0, rd_valid}, 32'h0);
        check("async.entry_valid", {24'b0, entry_valid}, 32'h0);
        idle_inputs();
        @(negedge clk);
        check_outputs("in_reset");
        rst_n = 1'b1;
        step("post_rst_rd0", 0, 0, '0, 1, 0, 0);
        check("post_rst_rd0.data_k", rd_data, 32'h0);
        check("post_rst_rd0.valid_k", {31'b0, rd_valid}, 32'h0);
        step("post_rst_rd5", 0, 0, '0, 1, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
